// File: rtl/prog_mem_responder.sv
// Memory-side responder for the core's 15-bit instruction / 8-bit data bus.
// Holds a DEPTH x 15 word store. Reads are combinational and writes are
// synchronous. A byte-serial loader fills the store while the core is held
// in reset, and the core is then released after RELEASE_CYCLES clocks.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// SERVE   | core running; responder answers reads and accepts byte stores
// LD_HI   | core held; waiting for the high byte of the next word, or ld_end
// LD_LO   | core held; waiting for the low byte, then the word is written
// RELEASE | core held for RELEASE_CYCLES clocks, then SERVE
module prog_mem_responder #(
  parameter int DEPTH          = 256,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic [7:0] Adr,
  input  logic       MemWrite,
  output logic [6:0] MemData1,
  inout  wire  [7:0] MemData2,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_end,
  output logic       ld_ready,
  output logic       core_reset,
  output logic [8:0] load_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);
  localparam logic [8:0]    DEPTH_W  = 9'(DEPTH);

  typedef enum logic [1:0] {SERVE, LD_HI, LD_LO, RELEASE} state_t;

  state_t        state;
  logic [RW-1:0] rel_cnt;
  logic [6:0]    hold;

  logic [14:0]   mem [DEPTH];

  logic          in_range;
  logic [AW-1:0] adr_idx;
  logic [AW-1:0] ld_idx;
  logic [14:0]   rd_word;
  logic          bus_drive;
  logic          serve_wr;
  logic          load_wr;
  logic [8:0]    count_next;

  // Addresses at or beyond DEPTH must never alias onto a real word, so the
  // range test uses the full address while the index uses only the low bits.
  assign in_range   = ({1'b0, Adr} < DEPTH_W);
  assign adr_idx    = Adr[AW-1:0];
  assign ld_idx     = load_count[AW-1:0];
  assign count_next = load_count + 9'd1;

  // Combinational read port; out-of-range addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[adr_idx];
    end
  end

  assign MemData1 = rd_word[14:8];

  // The responder only drives the data byte while serving a read; the core
  // owns the bus during its stores and the bus floats while the core is held.
  assign bus_drive = (state == SERVE) && !MemWrite;
  assign MemData2  = bus_drive ? rd_word[7:0] : 8'hzz;

  assign serve_wr = (state == SERVE) && MemWrite && in_range;
  assign load_wr  = (state == LD_LO) && ld_valid;

  // Word store: core byte stores touch only bits [7:0]; loader writes whole words.
  always_ff @(posedge ph1) begin
    if (serve_wr) begin
      mem[adr_idx][7:0] <= MemData2;
    end else if (load_wr) begin
      mem[ld_idx] <= {hold, ld_data};
    end
  end

  // Sequencing FSM with registered core_reset / ld_ready.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state      <= RELEASE;
      rel_cnt    <= '0;
      core_reset <= 1'b1;
      ld_ready   <= 1'b0;
      load_count <= '0;
      hold       <= '0;
    end else begin
      case (state)
        RELEASE: begin
          if (rel_cnt == REL_LAST) begin
            state      <= SERVE;
            rel_cnt    <= '0;
            core_reset <= 1'b0;
            ld_ready   <= 1'b0;
          end else begin
            rel_cnt <= rel_cnt + RW'(1);
          end
        end
        SERVE: begin
          if (ld_start) begin
            state      <= LD_HI;
            load_count <= '0;
            core_reset <= 1'b1;
            ld_ready   <= 1'b1;
          end
        end
        LD_HI: begin
          if (ld_valid) begin
            if (ld_end) begin
              // Terminating byte carries no data.
              state    <= RELEASE;
              ld_ready <= 1'b0;
            end else begin
              hold  <= ld_data[6:0];
              state <= LD_LO;
            end
          end
        end
        LD_LO: begin
          if (ld_valid) begin
            load_count <= count_next;
            if (count_next == DEPTH_W) begin
              state    <= RELEASE;
              ld_ready <= 1'b0;
            end else begin
              state <= LD_HI;
            end
          end
        end
        default: begin
          state      <= RELEASE;
          rel_cnt    <= '0;
          core_reset <= 1'b1;
          ld_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_mem_responder.md
Name: prog_mem_responder

Overview:
- Memory-side responder for the processor's 15-bit instruction / 8-bit data bus (Adr, MemWrite, MemData1[14:8], MemData2[7:0]).
- Holds a DEPTH x 15 word store. Reads are combinational. Writes are synchronous.
- A byte-serial program loader fills the store while the block holds the core in reset, then releases it.
- Sits beside the core in the top level. It is the far end of the core's memory interface.

Parameters:
DEPTH, 256, number of 15-bit words; valid range 2..256; addresses >= DEPTH read as 0 and ignore writes
RELEASE_CYCLES, 2, clock cycles core_reset stays high after reset deassertion or load completion; >= 1

Ports:
ph1  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high
Adr  input  8  word address from core
MemWrite  input  1  core store strobe, sampled at rising ph1
MemData1  output  7  instruction bits [14:8] of mem[Adr]
MemData2  inout  8  bits [7:0]: responder drives reads, core drives writes
ld_start  input  1  pulse: begin program load
ld_valid  input  1  loader byte valid
ld_data  input  8  loader byte
ld_end  input  1  qualifies an accepted byte in LD_HI state: terminate load, byte discarded
ld_ready  output  1  responder accepts a loader byte this cycle
core_reset  output  1  reset to the core
load_count  output  9  words written by the current or last load

Behaviour:
- Interface: one clock (ph1), rising-edge. Reset is asynchronous and active-high.
- Reset values:
  - state = RELEASE, release counter = 0.
  - core_reset = 1, ld_ready = 0, load_count = 0, hi-byte hold register = 0.
  - Memory contents are not reset.
- States: SERVE, LD_HI, LD_LO, RELEASE.
- RELEASE:
  - core_reset = 1, MemData2 = Z, MemWrite ignored.
  - Counter increments each cycle. At count RELEASE_CYCLES-1, go to SERVE and clear the counter.
  - After reset deassertion, core_reset is therefore high for exactly RELEASE_CYCLES rising edges.
- SERVE:
  - core_reset = 0, ld_ready = 0.
  - Read: MemData1 = mem[Adr][14:8] combinationally.
  - MemData2 = mem[Adr][7:0] when MemWrite = 0, else Z.
  - Write: on rising ph1 with MemWrite = 1 and Adr < DEPTH, mem[Adr][7:0] <= MemData2 value driven by the core. Bits [14:8] are unchanged.
  - A read of the same address in the next cycle returns the new byte (no forwarding needed within a cycle).
  - Adr >= DEPTH: MemData1 = 0; MemData2 = 0 when driven.
  - ld_start = 1: go to LD_HI, load_count <= 0, core_reset = 1 from the next cycle. A same-cycle MemWrite is still performed.
- LD_HI:
  - core_reset = 1, ld_ready = 1, MemData2 = Z, MemWrite ignored.
  - On ld_valid & ld_end: go to RELEASE, no store.
  - Else on ld_valid: hold <= ld_data[6:0] (bit 7 discarded), go to LD_LO.
- LD_LO:
  - core_reset = 1, ld_ready = 1. ld_end is ignored.
  - On ld_valid: mem[load_count[7:0]] <= {hold, ld_data}, load_count++.
  - If the new load_count == DEPTH, go to RELEASE; else go to LD_HI.
- ld_start is ignored outside SERVE.
- ld_valid without a byte slot (SERVE/RELEASE) is dropped; ld_ready = 0 there.
- Simultaneous ld_start and reset: reset wins.
- Reset mid-load: immediate RELEASE with load_count = 0. Words already stored are kept. The partial hi byte is lost.
- Bus contention rule: the responder never drives MemData2 while MemWrite = 1 or outside SERVE.
- load_count holds its final value in SERVE until the next ld_start.

Test Plan:
- Reset pulse: deassert reset, hold ld_valid = 0 -> core_reset = 1 for 2 rising edges then 0; ld_ready = 0 throughout; MemData2 = Z during RELEASE.
- Load 3 words:
  - Stimulus: ld_start, then bytes 0x52,0x34 / 0x7F,0xFF / 0x00,0x01, then 0x00 with ld_end.
  - Required: load_count = 3. core_reset falls 2 cycles after ld_end.
  - Required: Adr = 0 gives MemData1 = 0x52, MemData2 = 0x34. Adr = 1 gives 0x7F/0xFF. Adr = 2 gives 0x00/0x01.
- Store: with mem[0x10] = 0x2A_55, MemWrite = 1, Adr = 0x10, core drives 0xA5 for one edge -> responder at Z that cycle; next cycle MemData1 = 0x2A, MemData2 = 0xA5.
- Full load, DEPTH = 256: 512 bytes with no ld_end -> RELEASE entered after word 255; load_count = 256; bytes 513+ see ld_ready = 0.
- Reset mid-load: assert reset after word 5's lo byte and word 6's hi byte -> RELEASE, load_count = 0, mem[5] retained, mem[6] unchanged.
- Range check, DEPTH = 16:
  - Adr = 0x20 read -> MemData1 = 0, MemData2 = 0x00.
  - MemWrite to 0x20 -> no store occurs; mem[0x00] is unchanged.
  - 32-byte load ends automatically at load_count = 16.
